// File: rtl/updown_mod_counter_if.sv
// Control/status bundle for updown_mod_counter.
// Lets a driver and a monitor share one handle instead of a dozen loose wires.
interface updown_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             x;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_gray;
  logic             tc;
  logic             wrap;
  logic             load_err;

  modport master (
    output en, x, clear, load, load_val,
    input  q, q_gray, tc, wrap, load_err
  );

  modport slave (
    input  en, x, clear, load, load_val,
    output q, q_gray, tc, wrap, load_err
  );
endinterface

// File: rtl/gray_encode.sv
// Binary to reflected Gray code.
// Purely combinational.
module gray_encode #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);
  assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo-N counter with load, clear, wrap/saturate and Gray output.
// Q, wrap and load_err live in one register block; tc and Q_gray are decoded.
module updown_mod_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 3,
  parameter int SATURATE = 0
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_gray,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);
  if (WIDTH < 2 || WIDTH > 16 ||
      MODULUS < 2 || MODULUS > (1 << WIDTH) ||
      SATURATE < 0 || SATURATE > 1) begin : g_bad_param
    $error("updown_mod_counter: illegal parameter set");
  end

  // One extra bit so MODULUS == 2**WIDTH still compares correctly.
  localparam logic [WIDTH:0] LIM = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] TOP = (WIDTH+1)'(MODULUS - 1);

  logic at_top;
  logic at_bot;
  logic lv_bad;

  assign at_top = ({1'b0, Q} == TOP);
  assign at_bot = (Q == '0);
  assign lv_bad = ({1'b0, load_val} >= LIM);
  assign tc     = x ? at_top : at_bot;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      Q        <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (clear) begin
        Q <= '0;
      end else if (load) begin
        if (lv_bad) begin
          Q        <= TOP[WIDTH-1:0];
          load_err <= 1'b1;
        end else begin
          Q <= load_val;
        end
      end else if (en) begin
        if (x) begin
          if (at_top) begin
            wrap <= 1'b1;
            Q    <= (SATURATE != 0) ? Q : '0;
          end else begin
            Q <= Q + WIDTH'(1);
          end
        end else begin
          if (at_bot) begin
            wrap <= 1'b1;
            Q    <= (SATURATE != 0) ? Q : TOP[WIDTH-1:0];
          end else begin
            Q <= Q - WIDTH'(1);
          end
        end
      end
    end
  end

  gray_encode #(
    .WIDTH (WIDTH)
  ) u_gray (
    .bin  (Q),
    .gray (Q_gray)
  );
endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: count register width, range 2..16.
REQ-002 SHALL have parameter MODULUS, default 3: count range 0..MODULUS-1, range 2..2**WIDTH.
REQ-003 SHALL have parameter SATURATE, default 0: 0 = wrap at the range ends, 1 = hold at the range ends.
REQ-004 SHALL have port Clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  input  1  count enable.
REQ-007 SHALL have port x  input  1  direction: 1 = up, 0 = down.
REQ-008 SHALL have port clear  input  1  synchronous clear to 0.
REQ-009 SHALL have port load  input  1  synchronous load of load_val.
REQ-010 SHALL have port load_val  input  WIDTH  value to load.
REQ-011 SHALL have port Q  output  WIDTH  registered binary count.
REQ-012 SHALL have port Q_gray  output  WIDTH  Gray code of Q, combinational from Q.
REQ-013 SHALL have port tc  output  1  terminal count: Q==MODULUS-1 when x=1, Q==0 when x=0 (combinational).
REQ-014 SHALL have port wrap  output  1  registered one-cycle pulse: the previous edge wrapped (SATURATE=0) or was blocked at a limit (SATURATE=1).
REQ-015 SHALL have port load_err  output  1  registered one-cycle pulse: the previous edge loaded an out-of-range value.

Function
REQ-016 SHALL apply priority per edge: clear > load > en count > hold.
REQ-017 SHALL set Q=0 on an edge with clear=1, with wrap=0 and load_err=0 on the next cycle.
REQ-018 SHALL set Q=load_val on an edge with load=1, clear=0 and load_val<MODULUS, with load_err=0.
REQ-019 SHALL set Q=MODULUS-1 and pulse load_err=1 for one cycle when load_val>=MODULUS.
REQ-020 SHALL, with en=1 and x=1 (up), move Q+1 when Q<MODULUS-1; at Q=MODULUS-1, go to Q=0 (SATURATE=0) or hold (SATURATE=1), with wrap=1 for one cycle in both cases.
REQ-021 SHALL, with en=1 and x=0 (down), move Q-1 when Q>0; at Q=0, go to Q=MODULUS-1 (SATURATE=0) or hold (SATURATE=1), with wrap=1 for one cycle in both cases.
REQ-022 SHALL hold Q and drive wrap=0 when en=0 and neither clear nor load is asserted.
REQ-023 SHALL give one edge of latency from input to Q, wrap and load_err; tc and Q_gray follow Q combinationally.
REQ-024 SHALL take effect on the same edge when x changes, with no extra latency.
REQ-025 SHALL compute Q_gray as Q ^ (Q>>1).
REQ-026 SHALL keep Q within 0..MODULUS-1 at all times; no illegal state is reachable.
REQ-027 SHALL be hazard-free when MODULUS=2**WIDTH, with no width overflow in the compare or increment.

Reset
REQ-028 SHALL, while reset=0, asynchronously force Q=0, wrap=0 and load_err=0, independent of Clk.
REQ-029 SHALL resume counting from 0 on the first rising Clk edge after reset deasserts, including after a reset asserted mid-count or mid-load.

Structure
REQ-030 SHALL contain no shared package; the parameters are local to the module.
REQ-031 SHALL implement Gray encoding in one sub-module, gray_encode, parametrised by WIDTH.
REQ-032 SHALL hold all sequential state in a single always block: Q, wrap and load_err.
REQ-033 SHALL reject illegal parameter combinations (MODULUS<2 or MODULUS>2**WIDTH) at elaboration.

Verification
REQ-034 SHALL cover default parameters, en=1, x=1 for 4 edges from reset: Q=0,1,2,0,1; wrap high only in the cycle after 2->0; tc=1 when Q=2.
REQ-035 SHALL cover default parameters, en=1, x=0 from reset: Q=0,2,1,0,2; wrap after each 0->2.
REQ-036 SHALL cover WIDTH=4, MODULUS=10, SATURATE=1, load_val=9 then 3 up-edges: Q=9,9,9,9; wrap=1 on each blocked edge; then x=0: Q=8.
REQ-037 SHALL cover WIDTH=4, MODULUS=10, load_val=12: Q=9, load_err=1 for exactly one cycle; same edge with clear=1: Q=0, load_err=0.
REQ-038 SHALL cover reset pulled low between edges at Q=5: Q=0 immediately without a clock edge, and wrap/load_err=0.
REQ-039 SHALL cover WIDTH=3, MODULUS=8, up from 0 through 7 to 0: Q_gray=000,001,011,010,110,111,101,100,000, with exactly one bit changing per step.
